// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the big-endian data-memory responder.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // Byte enables: bit 3 is lane 0 (bits [31:24]) because the array is big-endian.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: lane_mask = 4'b1000 >> off;
         SZ_HALF: lane_mask = off[1] ? 4'b0011 : 4'b1100;
         SZ_WORD: lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      logic [15:0] h;
      sh = word << {off, 3'b000};
      h  = off[1] ? word[15:0] : word[31:16];
      case (size)
         SZ_BYTE: load_extract = {{24{sh[31] & ~uns}}, sh[31:24]};
         SZ_HALF: load_extract = {{16{h[15] & ~uns}}, h};
         SZ_WORD: load_extract = word;
         default: load_extract = 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables; contents are never reset.
module dmem_array #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  rd_en,
   input  logic [3:0]            be,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (rd_en) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: latency-programmable FSM, alignment/range checks and
// big-endian lane steering in front of a byte-enabled RAM.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ_Valid,
   output logic        REQ_Ready,
   input  logic        REQ_Write,
   input  logic [31:0] REQ_Addr,
   input  logic [31:0] REQ_WData,
   input  logic [1:0]  REQ_Size,
   input  logic        REQ_Unsigned,
   output logic        RSP_Valid,
   output logic [31:0] RSP_RData,
   output logic        RSP_Error,
   output logic        MEM_Stall
);

   localparam bit ONE_CYCLE = (LATENCY == 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_write, lat_uns;
   logic [31:0] lat_addr, lat_wdata;
   logic [1:0]  lat_size;

   logic        accept, go_resp, bypass;
   logic        cur_write, cur_err, lat_err;
   logic [31:0] cur_addr, cur_wdata, ram_wdata, ram_rdata;
   logic [1:0]  cur_size;
   logic [3:0]  ram_be;

   function automatic logic acc_err(input logic [31:0] a, input logic [1:0] sz);
      return (sz == 2'b11) || misaligned(sz, a[1:0]) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
   endfunction

   assign REQ_Ready = (state != BUSY) && !RESET;
   assign accept    = REQ_Valid && REQ_Ready;

   // With LATENCY 1 the accept edge is also the RAM edge, so the live request drives the array.
   assign bypass    = accept && ONE_CYCLE;
   assign go_resp   = !RESET && (bypass || (state == BUSY && cnt == 4'd1));
   assign cur_write = bypass ? REQ_Write : lat_write;
   assign cur_addr  = bypass ? REQ_Addr  : lat_addr;
   assign cur_wdata = bypass ? REQ_WData : lat_wdata;
   assign cur_size  = bypass ? REQ_Size  : lat_size;
   assign cur_err   = acc_err(cur_addr, cur_size);

   always_comb begin
      ram_wdata = cur_wdata;
      case (cur_size)
         SZ_BYTE: ram_wdata = {4{cur_wdata[7:0]}};
         SZ_HALF: ram_wdata = {2{cur_wdata[15:0]}};
         default: ram_wdata = cur_wdata;
      endcase
   end

   assign ram_be = (go_resp && cur_write && !cur_err) ? lane_mask(cur_size, cur_addr[1:0]) : 4'b0000;

   dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .clk   (CLK),
      .addr  (cur_addr[ADDR_WIDTH+1:2]),
      .rd_en (go_resp && !cur_write),
      .be    (ram_be),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_uns   <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_size  <= 2'b00;
      end else if (accept) begin
         lat_write <= REQ_Write;
         lat_uns   <= REQ_Unsigned;
         lat_addr  <= REQ_Addr;
         lat_wdata <= REQ_WData;
         lat_size  <= REQ_Size;
         cnt       <= 4'(LATENCY - 1);
         state     <= ONE_CYCLE ? RESP : BUSY;
      end else if (state == BUSY) begin
         if (cnt == 4'd1) state <= RESP;
         cnt <= cnt - 4'd1;
      end else begin
         state <= IDLE;
      end
   end

   // In RESP the latched fields always describe the access being answered.
   assign lat_err   = acc_err(lat_addr, lat_size);
   assign RSP_Valid = (state == RESP) && !RESET;
   assign RSP_Error = RSP_Valid && lat_err;
   assign RSP_RData = (RSP_Valid && !lat_err && !lat_write)
                      ? load_extract(ram_rdata, lat_size, lat_addr[1:0], lat_uns) : 32'd0;
   assign MEM_Stall = !RESET && ((REQ_Valid && !REQ_Ready) || (state == BUSY) || accept);

endmodule
